// File: rtl/cvxif_pkg.sv
// CV-X-IF coprocessor interface types shared by the core side and the responder.
package cvxif_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned X_NUM_RS   = 2;
   localparam int unsigned X_ID_WIDTH = 4;

   typedef struct packed {
      logic [31:0]                         instr;
      logic [X_NUM_RS-1:0][XLEN-1:0]       rs;
      logic [X_NUM_RS-1:0]                 rs_valid;
      logic [X_ID_WIDTH-1:0]               id;
   } x_issue_req_t;

   typedef struct packed {
      logic accept;
      logic writeback;
      logic dualwrite;
      logic dualread;
      logic loadstore;
      logic exc;
   } x_issue_resp_t;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic                  x_commit_kill;
   } x_commit_t;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic [XLEN-1:0]       data;
      logic [4:0]            rd;
      logic                  we;
      logic                  exc;
      logic [5:0]            exccode;
   } x_result_t;

   typedef struct packed {
      logic          x_issue_valid;
      x_issue_req_t  x_issue_req;
      logic          x_commit_valid;
      x_commit_t     x_commit;
      logic          x_result_ready;
   } cvxif_req_t;

   typedef struct packed {
      logic          x_issue_ready;
      x_issue_resp_t x_issue_resp;
      logic          x_result_valid;
      x_result_t     x_result;
   } cvxif_resp_t;

endpackage

// File: rtl/cvxif_responder_pkg.sv
// Decode constants and the result-queue entry type of the custom-3 responder.
package cvxif_responder_pkg;

   localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
   localparam logic [5:0] EXC_CODE       = 6'd2;

   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,
      F3_NOP  = 3'b001,
      F3_EXC  = 3'b010,
      F3_MADD = 3'b011
   } funct3_e;

   typedef struct packed {
      logic [cvxif_pkg::X_ID_WIDTH-1:0] id;
      logic [cvxif_pkg::XLEN-1:0]       data;
      logic [4:0]                       rd;
      logic                             we;
      logic                             exc;
      logic [5:0]                       exccode;
   } result_entry_t;

endpackage

// File: rtl/cvxif_result_fifo.sv
// In-order result queue of the responder; DEPTH must be a power of two so the
// pointers wrap naturally.
module cvxif_result_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = logic
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   push_i,
   input  entry_t push_data_i,
   input  logic   pop_i,
   output entry_t head_o,
   output logic   empty_o,
   output logic   full_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // NOTE: every always_comb output is given a default first, so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: payload storage has no reset; an empty count hides stale entries.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/cvxif_responder.sv
// CV-X-IF custom-3 responder: ADD/NOP/EXC complete in one cycle; MADD (with
// CVXIF_RESPONDER_MULTICYCLE_EN defined) runs MULTI_LATENCY cycles and can be killed.
module cvxif_responder
   import cvxif_pkg::*;
   import cvxif_responder_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned MULTI_LATENCY = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  cvxif_req_t  cvxif_req_i,
   output cvxif_resp_t cvxif_resp_o
);

   logic [31:0]   instr;
   logic [2:0]    funct3;
   logic          rs_ok;
   x_issue_resp_t issue_resp;
   result_entry_t dec_entry, fifo_wdata, fifo_head;
   logic          dec_madd, issue_ready, issue_hs, single_push, madd_push, busy;
   logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic          ready_en_q, ready_en_d;
   logic          unused_bits;

   assign instr  = cvxif_req_i.x_issue_req.instr;
   assign funct3 = instr[14:12];
   assign rs_ok  = &cvxif_req_i.x_issue_req.rs_valid;

   always_comb begin
      issue_resp        = '0;
      dec_madd          = 1'b0;
      dec_entry         = '0;
      dec_entry.id      = cvxif_req_i.x_issue_req.id;
      dec_entry.rd      = instr[11:7];
      if (instr[6:0] == OPCODE_CUSTOM3) begin
         case (funct3)
            F3_ADD: if (rs_ok) begin
               issue_resp.accept    = 1'b1;
               issue_resp.writeback = 1'b1;
               dec_entry.data = cvxif_req_i.x_issue_req.rs[0] + cvxif_req_i.x_issue_req.rs[1];
               dec_entry.we   = 1'b1;
            end
            F3_NOP: issue_resp.accept = 1'b1;
            F3_EXC: begin
               issue_resp.accept = 1'b1;
               issue_resp.exc    = 1'b1;
               dec_entry.exc     = 1'b1;
               dec_entry.exccode = EXC_CODE;
            end
            F3_MADD: begin
`ifdef CVXIF_RESPONDER_MULTICYCLE_EN
               if (rs_ok) begin
                  issue_resp.accept    = 1'b1;
                  issue_resp.writeback = 1'b1;
                  dec_madd       = 1'b1;
                  dec_entry.data = cvxif_req_i.x_issue_req.rs[0] + cvxif_req_i.x_issue_req.rs[1]
                                   + XLEN'(1);
                  dec_entry.we   = 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   // Ready is held low until the first clock edge after reset release.
   assign ready_en_d  = 1'b1;
   assign issue_ready = ready_en_q && !fifo_full && !busy;
   assign issue_hs    = cvxif_req_i.x_issue_valid && issue_ready;
   assign single_push = issue_hs && issue_resp.accept && !dec_madd;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ready_en_q <= 1'b0;
      else         ready_en_q <= ready_en_d;
   end

`ifdef CVXIF_RESPONDER_MULTICYCLE_EN
   localparam int unsigned LAT_W = $clog2(MULTI_LATENCY);

   logic          busy_q, busy_d, kill;
   result_entry_t busy_entry_q, busy_entry_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;

   // A matching kill wins over completion, even in the counter's final cycle.
   assign kill = busy_q && cvxif_req_i.x_commit_valid && cvxif_req_i.x_commit.x_commit_kill
                 && (cvxif_req_i.x_commit.id == busy_entry_q.id);
   assign madd_push = busy_q && (cnt_q == '0) && !kill;
   assign busy      = busy_q;

   always_comb begin
      busy_d       = busy_q;
      busy_entry_d = busy_entry_q;
      cnt_d        = cnt_q;
      if (busy_q) begin
         if (kill || cnt_q == '0) busy_d = 1'b0;
         else                     cnt_d  = cnt_q - LAT_W'(1);
      end
      if (issue_hs && dec_madd) begin
         busy_d       = 1'b1;
         busy_entry_d = dec_entry;
         cnt_d        = LAT_W'(MULTI_LATENCY - 1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q       <= 1'b0;
         busy_entry_q <= '0;
         cnt_q        <= '0;
      end else begin
         busy_q       <= busy_d;
         busy_entry_q <= busy_entry_d;
         cnt_q        <= cnt_d;
      end
   end

   assign fifo_wdata  = madd_push ? busy_entry_q : dec_entry;
   assign unused_bits = ^instr[31:15];
`else
   assign busy        = 1'b0;
   assign madd_push   = 1'b0;
   assign fifo_wdata  = dec_entry;
   assign unused_bits = ^{instr[31:15], cvxif_req_i.x_commit_valid, cvxif_req_i.x_commit,
                          32'(MULTI_LATENCY)};
`endif

   assign fifo_push = single_push || madd_push;
   assign fifo_pop  = !fifo_empty && cvxif_req_i.x_result_ready;

   cvxif_result_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (result_entry_t)
   ) i_result_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (fifo_push),
      .push_data_i (fifo_wdata),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   always_comb begin
      cvxif_resp_o = '0;
      if (rst_ni) begin
         cvxif_resp_o.x_issue_ready  = issue_ready;
         cvxif_resp_o.x_issue_resp   = issue_resp;
         cvxif_resp_o.x_result_valid = !fifo_empty;
         if (!fifo_empty) begin
            cvxif_resp_o.x_result.id      = fifo_head.id;
            cvxif_resp_o.x_result.data    = fifo_head.data;
            cvxif_resp_o.x_result.rd      = fifo_head.rd;
            cvxif_resp_o.x_result.we      = fifo_head.we;
            cvxif_resp_o.x_result.exc     = fifo_head.exc;
            cvxif_resp_o.x_result.exccode = fifo_head.exccode;
         end
      end
   end

endmodule

// File: tb/tb_cvxif_responder.sv
// Self-checking bench for cvxif_responder: vector table plus hand sequences,
// with a scoreboard queue of expected results compared as the DUT returns them.
module tb_cvxif_responder;
   import cvxif_pkg::*;
   import cvxif_responder_pkg::*;

   localparam logic [6:0] OP_CUSTOM3 = 7'h7B;
   localparam logic [6:0] OP_REG     = 7'h33;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] rs0;
      logic [31:0] rs1;
      logic [1:0]  rsv;
      logic        acc;
      logic        wb;
      logic        exc;
   } vec_t;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   cvxif_req_t    req;
   cvxif_resp_t   resp;
   result_entry_t sb[$];
   result_entry_t mon_act, mon_exp;
   vec_t          vecs[$];
   int            pass_cnt = 0;
   int            total_cnt = 0;
   logic          madd_acc;

   cvxif_responder #(.FIFO_DEPTH(4), .MULTI_LATENCY(3)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cvxif_req_i  (req),
      .cvxif_resp_o (resp)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] mk_instr(logic [6:0] op, logic [2:0] f3, logic [4:0] rd);
      return {17'd0, f3, rd, op};
   endfunction

   // Independent reference for the result an accepted instruction produces.
   function automatic result_entry_t model(logic [31:0] instr, logic [31:0] a, logic [31:0] b,
                                           logic [3:0] id);
      result_entry_t m;
      m    = '0;
      m.id = id;
      m.rd = instr[11:7];
      case (instr[14:12])
         3'b000: begin m.data = a + b;         m.we = 1'b1; end
         3'b010: begin m.exc  = 1'b1;          m.exccode = 6'd2; end
         3'b011: begin m.data = a + b + 32'd1; m.we = 1'b1; end
         default: ;
      endcase
      return m;
   endfunction

   // Scoreboard consumer: compare every popped result with the oldest expectation.
   always @(negedge clk_i) begin
      if (rst_ni && resp.x_result_valid && req.x_result_ready) begin
         mon_act         = '0;
         mon_act.id      = resp.x_result.id;
         mon_act.data    = resp.x_result.data;
         mon_act.rd      = resp.x_result.rd;
         mon_act.we      = resp.x_result.we;
         mon_act.exc     = resp.x_result.exc;
         mon_act.exccode = resp.x_result.exccode;
         check("result_pending", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            check("result_entry", 64'(mon_act), 64'(mon_exp));
         end
      end
   end

   // Starts and ends at posedge+1; waits a bounded time for issue_ready.
   task automatic issue(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] rsv, input logic exp_acc,
                        input logic exp_wb, input logic exp_exc, input bit sb_push);
      int waited = 0;
      req.x_issue_valid              = 1'b1;
      req.x_issue_req.id             = id;
      req.x_issue_req.instr          = instr;
      req.x_issue_req.rs[0]          = a;
      req.x_issue_req.rs[1]          = b;
      req.x_issue_req.rs_valid       = rsv;
      @(negedge clk_i);
      while (!resp.x_issue_ready && waited < 50) begin
         @(negedge clk_i);
         waited++;
      end
      check("issue_ready_wait", 64'(resp.x_issue_ready), 64'd1);
      check("accept", 64'(resp.x_issue_resp.accept), 64'(exp_acc));
      check("writeback", 64'(resp.x_issue_resp.writeback), 64'(exp_wb));
      check("issue_exc", 64'(resp.x_issue_resp.exc), 64'(exp_exc));
      if (exp_acc && sb_push && resp.x_issue_ready) sb.push_back(model(instr, a, b, id));
      @(posedge clk_i);
      #1 req.x_issue_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      req.x_result_ready = 1'b1;
      repeat (2) @(posedge clk_i);
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk_i);
         n++;
      end
      #1 check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic watch_quiet(input string name, input int n);
      bit seen = 1'b0;
      repeat (n) begin
         @(negedge clk_i);
         if (resp.x_result_valid) seen = 1'b1;
      end
      @(posedge clk_i);
      #1 check(name, 64'(seen), 64'd0);
   endtask

   task automatic pulse_commit(input logic [3:0] id, input logic kill);
      req.x_commit_valid         = 1'b1;
      req.x_commit.id            = id;
      req.x_commit.x_commit_kill = kill;
      @(posedge clk_i);
      #1 req.x_commit_valid = 1'b0;
      req.x_commit.x_commit_kill = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected the run to finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef CVXIF_RESPONDER_MULTICYCLE_EN
      madd_acc = 1'b1;
`else
      madd_acc = 1'b0;
`endif
      vecs.push_back('{"add_basic", mk_instr(OP_CUSTOM3, 3'b000, 5'd1), 32'd5, 32'd7, 2'b11, 1, 1, 0});
      vecs.push_back('{"add_wrap", mk_instr(OP_CUSTOM3, 3'b000, 5'd31), 32'hFFFF_FFFF, 32'd2, 2'b11, 1, 1, 0});
      vecs.push_back('{"nop", mk_instr(OP_CUSTOM3, 3'b001, 5'd4), 32'd9, 32'd9, 2'b00, 1, 0, 0});
      vecs.push_back('{"exc", mk_instr(OP_CUSTOM3, 3'b010, 5'd6), 32'd1, 32'd2, 2'b00, 1, 0, 1});
      vecs.push_back('{"add_rs1_invalid", mk_instr(OP_CUSTOM3, 3'b000, 5'd2), 32'd1, 32'd1, 2'b01, 0, 0, 0});
      vecs.push_back('{"opcode_reg", mk_instr(OP_REG, 3'b000, 5'd2), 32'd1, 32'd1, 2'b11, 0, 0, 0});
      vecs.push_back('{"funct3_100", mk_instr(OP_CUSTOM3, 3'b100, 5'd3), 32'd1, 32'd1, 2'b11, 0, 0, 0});
      vecs.push_back('{"funct3_111", mk_instr(OP_CUSTOM3, 3'b111, 5'd3), 32'd1, 32'd1, 2'b11, 0, 0, 0});
      vecs.push_back('{"madd", mk_instr(OP_CUSTOM3, 3'b011, 5'd9), 32'd10, 32'd20, 2'b11, madd_acc, madd_acc, 0});

      req    = '0;
      rst_ni = 1'b0;
      #1 check("reset_resp_zero", 64'(resp), 64'd0);
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i) check("ready_low_after_release", 64'(resp.x_issue_ready), 64'd0);
      @(negedge clk_i) check("ready_rises", 64'(resp.x_issue_ready), 64'd1);
      @(posedge clk_i);
      #1 req.x_result_ready = 1'b1;

      // ADD id=3, 5+7: result visible one cycle after the handshake.
      issue(4'd3, mk_instr(OP_CUSTOM3, 3'b000, 5'd10), 32'd5, 32'd7, 2'b11, 1, 1, 0, 1);
      @(negedge clk_i);
      check("lat1_valid", 64'(resp.x_result_valid), 64'd1);
      check("lat1_id", 64'(resp.x_result.id), 64'd3);
      check("lat1_data", 64'(resp.x_result.data), 64'd12);
      check("lat1_we", 64'(resp.x_result.we), 64'd1);
      @(posedge clk_i);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         issue(4'(i), vecs[i].instr, vecs[i].rs0, vecs[i].rs1, vecs[i].rsv,
               vecs[i].acc, vecs[i].wb, vecs[i].exc, 1);
      end
      drain();

      // Non-custom opcode: rejected, nothing ever comes back.
      issue(4'd7, mk_instr(OP_REG, 3'b000, 5'd1), 32'd3, 32'd4, 2'b11, 0, 0, 0, 1);
      watch_quiet("reject_no_result", 20);

      // Fill the queue with result_ready low, then release one entry.
      req.x_result_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         issue(4'(8 + i), mk_instr(OP_CUSTOM3, 3'b000, 5'(i)), 32'(i), 32'd100, 2'b11, 1, 1, 0, 1);
      @(negedge clk_i);
      check("full_ready_low", 64'(resp.x_issue_ready), 64'd0);
      check("full_valid", 64'(resp.x_result_valid), 64'd1);
      @(posedge clk_i);
      #1 req.x_result_ready = 1'b1;
      @(posedge clk_i);
      #1 req.x_result_ready = 1'b0;
      @(negedge clk_i) check("pop_ready_back", 64'(resp.x_issue_ready), 64'd1);
      @(posedge clk_i);
      #1 drain();

`ifdef CVXIF_RESPONDER_MULTICYCLE_EN
      // MADD blocks issue for three cycles, then results return in order.
      issue(4'd1, mk_instr(OP_CUSTOM3, 3'b011, 5'd11), 32'd1, 32'd1, 2'b11, 1, 1, 0, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i) check("madd_busy", 64'(resp.x_issue_ready), 64'd0);
         @(posedge clk_i);
         #1;
      end
      @(negedge clk_i) check("madd_ready_back", 64'(resp.x_issue_ready), 64'd1);
      @(posedge clk_i);
      #1 issue(4'd2, mk_instr(OP_CUSTOM3, 3'b000, 5'd12), 32'd2, 32'd2, 2'b11, 1, 1, 0, 1);
      drain();

      // Kill of the busy id one cycle after issue: no result, busy clears.
      issue(4'd5, mk_instr(OP_CUSTOM3, 3'b011, 5'd13), 32'd4, 32'd4, 2'b11, 1, 1, 0, 0);
      pulse_commit(4'd5, 1'b1);
      @(negedge clk_i) check("kill_ready_back", 64'(resp.x_issue_ready), 64'd1);
      @(posedge clk_i);
      #1 watch_quiet("kill_no_result", 8);

      // Non-matching kill and a plain commit leave the op running.
      issue(4'd5, mk_instr(OP_CUSTOM3, 3'b011, 5'd14), 32'd6, 32'd7, 2'b11, 1, 1, 0, 1);
      pulse_commit(4'd6, 1'b1);
      pulse_commit(4'd5, 1'b0);
      drain();

      // Kill in the cycle the counter reaches zero still suppresses the result.
      issue(4'd7, mk_instr(OP_CUSTOM3, 3'b011, 5'd15), 32'd8, 32'd8, 2'b11, 1, 1, 0, 0);
      repeat (2) @(posedge clk_i);
      #1 pulse_commit(4'd7, 1'b1);
      watch_quiet("kill_at_zero_no_result", 8);
`else
      issue(4'd1, mk_instr(OP_CUSTOM3, 3'b011, 5'd11), 32'd1, 32'd1, 2'b11, 0, 0, 0, 1);
      @(negedge clk_i) check("madd_off_not_busy", 64'(resp.x_issue_ready), 64'd1);
      @(posedge clk_i);
      #1 watch_quiet("madd_off_no_result", 8);
`endif

      // Asynchronous reset with two results queued.
      req.x_result_ready = 1'b0;
      issue(4'd12, mk_instr(OP_CUSTOM3, 3'b000, 5'd1), 32'd1, 32'd2, 2'b11, 1, 1, 0, 1);
      issue(4'd13, mk_instr(OP_CUSTOM3, 3'b000, 5'd2), 32'd3, 32'd4, 2'b11, 1, 1, 0, 1);
      #2 rst_ni = 1'b0;
      req.x_issue_valid        = 1'b1;
      req.x_issue_req.instr    = mk_instr(OP_CUSTOM3, 3'b000, 5'd3);
      req.x_issue_req.rs_valid = 2'b11;
      #1 check("async_rst_valid", 64'(resp.x_result_valid), 64'd0);
      check("async_rst_resp_zero", 64'(resp), 64'd0);
      sb.delete();
      req.x_issue_valid = 1'b0;
      repeat (2) @(posedge clk_i);
      #3 rst_ni = 1'b1;
      @(negedge clk_i) check("rst2_ready_low", 64'(resp.x_issue_ready), 64'd0);
      @(negedge clk_i) check("rst2_ready_rises", 64'(resp.x_issue_ready), 64'd1);
      @(posedge clk_i);
      #1 req.x_result_ready = 1'b1;
      watch_quiet("rst_queue_empty", 10);
      check("sb_final_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
